// File: rtl/vid_bus_pkg.sv
// Shared definitions for the video bus: command encoding, burst length
// decode and the arbiter bid values used by every bus agent.
package vid_bus_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE    = 3'b000,
        CMD_WR_DATA = 3'b001,
        CMD_RD_REQ  = 3'b010,
        CMD_RD_DATA = 3'b011,
        CMD_WR_REQ  = 3'b100,
        CMD_WR_RESP = 3'b101
    } cmd_t;

    localparam logic [1:0] REQ_BID  = 2'b11;
    localparam logic [1:0] REQ_NONE = 2'b00;

    // Burst length code to beat count: 00->1, 01->2, 10->4, 11->8.
    function automatic logic [3:0] len_to_beats(input logic [1:0] len);
        logic [3:0] beats;
        case (len)
            2'b00:   beats = 4'd1;
            2'b01:   beats = 4'd2;
            2'b10:   beats = 4'd4;
            default: beats = 4'd8;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous frame-buffer RAM, 2^DEPTH_LOG2 x 32 bits.
// Ports:
//   clk    - clock
//   we     - write enable; wdata is stored at addr on the rising edge
//   addr   - word index shared by read and write
//   wdata  - write data
//   rdata  - registered read data (mem[addr] captured at each edge)
// Contents are deliberately not reset.
module fb_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/fb_mem_responder.sv
// Frame-buffer responder on the video bus. Accepts burst writes that load
// RGB pixel words and answers burst read requests, bidding for the bus
// before each response.
// Ports:
//   clk, reset_n         - clock, async active-low reset
//   selin/cmdin/lenin    - request qualifier, bus command, burst length code
//   addrdatain           - byte address (requests) or write data (001 beats)
//   srcin                - requester ID sampled with a request
//   ackin                - arbiter grant
//   reqout               - arbiter bid
//   cmdout/lenout/reqtar - response command, length code and target ID
//   addrdataout          - read data or write-response start address
//   busy                 - not idle
//   err_cnt              - saturating protocol-error count
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a selected read or write request
// S_RD_BID  | bidding for the bus; first word is prefetched from RAM
// S_RD_DATA | driving one read beat per cycle, grant assumed locked
// S_WR_DATA | accepting write beats; 000 stalls, anything else aborts
// S_WR_BID  | bidding for the bus to send the write response
// S_WR_RESP | single write-response cycle
module fb_mem_responder
    import vid_bus_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [31:0] addrdatain,
    input  logic [3:0]  srcin,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [2:0]  cmdout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [3:0]  reqtar,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_BID,
        S_RD_DATA,
        S_WR_DATA,
        S_WR_BID,
        S_WR_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            len_q, len_d;
    logic [3:0]            src_q, src_d;
    logic [31:0]           start_q, start_d;
    logic [7:0]            err_q;
    logic                  err_inc;
    logic                  ram_we;
    logic [31:0]           ram_rdata;

    cmd_t                  cmd;
    logic                  req_seen;

    cmd_t                  cmdout_q, cmdout_d;
    logic [1:0]            reqout_q, reqout_d;
    logic [1:0]            lenout_q, lenout_d;
    logic [3:0]            reqtar_q, reqtar_d;
    logic                  busy_q, busy_d;

    assign cmd      = cmd_t'(cmdin);
    assign req_seen = selin && (cmd == CMD_RD_REQ || cmd == CMD_WR_REQ);

    // The RAM is always addressed by the running index: in S_RD_BID this
    // prefetches the first word, in S_RD_DATA it fetches the next beat.
    fb_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (addrdatain),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        src_d   = src_q;
        start_d = start_q;
        err_inc = 1'b0;
        ram_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (selin && (cmd == CMD_RD_REQ || cmd == CMD_WR_REQ)) begin
                    idx_d   = addrdatain[DEPTH_LOG2+1:2];
                    cnt_d   = len_to_beats(lenin) - 4'd1;
                    len_d   = lenin;
                    src_d   = srcin;
                    start_d = addrdatain;
                    state_d = (cmd == CMD_RD_REQ) ? S_RD_BID : S_WR_DATA;
                end
            end
            S_RD_BID: begin
                err_inc = req_seen;
                if (ackin) begin
                    // Step past the prefetched word so the next beat is
                    // fetched while the first one is on the bus.
                    idx_d   = idx_q + DEPTH_LOG2'(1);
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                err_inc = req_seen;
                idx_d   = idx_q + DEPTH_LOG2'(1);
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WR_DATA: begin
                case (cmd)
                    CMD_WR_DATA: begin
                        ram_we = 1'b1;
                        idx_d  = idx_q + DEPTH_LOG2'(1);
                        if (cnt_q == 4'd0) begin
                            state_d = S_WR_BID;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    CMD_IDLE: begin
                    end
                    default: begin
                        // Abort counts once, even when the offending
                        // command is itself a selected request.
                        err_inc = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_WR_BID: begin
                err_inc = req_seen;
                if (ackin) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                err_inc = req_seen;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response outputs are registered from the next state so they line up
    // with the state they describe.
    always_comb begin
        cmdout_d = CMD_IDLE;
        lenout_d = 2'b00;
        reqtar_d = 4'd0;
        if (state_d == S_RD_DATA) begin
            cmdout_d = CMD_RD_DATA;
            lenout_d = len_d;
            reqtar_d = src_d;
        end else if (state_d == S_WR_RESP) begin
            cmdout_d = CMD_WR_RESP;
            lenout_d = len_d;
            reqtar_d = src_d;
        end
        reqout_d = (state_d != S_IDLE) ? REQ_BID : REQ_NONE;
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= 4'd0;
            len_q    <= 2'b00;
            src_q    <= 4'd0;
            start_q  <= 32'd0;
            err_q    <= 8'd0;
            cmdout_q <= CMD_IDLE;
            reqout_q <= REQ_NONE;
            lenout_q <= 2'b00;
            reqtar_q <= 4'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            src_q    <= src_d;
            start_q  <= start_d;
            if (err_inc && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
            cmdout_q <= cmdout_d;
            reqout_q <= reqout_d;
            lenout_q <= lenout_d;
            reqtar_q <= reqtar_d;
            busy_q   <= busy_d;
        end
    end

    // Read data comes straight from the RAM output register; the select is
    // itself a register, so there is no input-to-output combinational path.
    always_comb begin
        addrdataout = 32'd0;
        if (cmdout_q == CMD_RD_DATA) begin
            addrdataout = ram_rdata;
        end else if (cmdout_q == CMD_WR_RESP) begin
            addrdataout = start_q;
        end
    end

    assign cmdout  = cmdout_q;
    assign reqout  = reqout_q;
    assign lenout  = lenout_q;
    assign reqtar  = reqtar_q;
    assign busy    = busy_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_fb_mem_responder.sv
// Directed self-checking bench for fb_mem_responder.
module tb_fb_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        selin;
    logic [2:0]  cmdin;
    logic [1:0]  lenin;
    logic [31:0] addrdatain;
    logic [3:0]  srcin;
    logic        ackin;
    logic [1:0]  reqout;
    logic [2:0]  cmdout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [3:0]  reqtar;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] wbuf [8];
    logic [31:0] rbuf [8];

    localparam logic [2:0] C_IDLE = 3'b000;
    localparam logic [2:0] C_WD   = 3'b001;
    localparam logic [2:0] C_RREQ = 3'b010;
    localparam logic [2:0] C_RD   = 3'b011;
    localparam logic [2:0] C_WREQ = 3'b100;
    localparam logic [2:0] C_WRSP = 3'b101;

    fb_mem_responder #(.DEPTH_LOG2(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .selin       (selin),
        .cmdin       (cmdin),
        .lenin       (lenin),
        .addrdatain  (addrdatain),
        .srcin       (srcin),
        .ackin       (ackin),
        .reqout      (reqout),
        .cmdout      (cmdout),
        .lenout      (lenout),
        .addrdataout (addrdataout),
        .reqtar      (reqtar),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [2:0] c, input logic [1:0] l,
                         input logic [31:0] ad, input logic [3:0] src, input logic a);
        selin      = s;
        cmdin      = c;
        lenin      = l;
        addrdatain = ad;
        srcin      = src;
        ackin      = a;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_reqout"}, 32'(reqout), 32'd0);
        chk({tag, "_cmdout"}, 32'(cmdout), 32'd0);
        chk({tag, "_lenout"}, 32'(lenout), 32'd0);
        chk({tag, "_addrdataout"}, addrdataout, 32'd0);
        chk({tag, "_reqtar"}, 32'(reqtar), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // Writes 1<<len words from wbuf, then waits one cycle in the bid state
    // before granting and checks the write response.
    task automatic do_write(input logic [31:0] addr, input logic [1:0] len, input logic [3:0] sid);
        int n;
        n = 1 << len;
        drive(1'b1, C_WREQ, len, addr, sid, 1'b0);
        tick();
        chk("wr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, C_WD, 2'b00, wbuf[i], 4'd0, 1'b0);
            tick();
        end
        drive(1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, 1'b0);
        tick();
        chk("wr_bid_reqout", 32'(reqout), 32'd3);
        chk("wr_bid_cmdout", 32'(cmdout), 32'(C_IDLE));
        ackin = 1'b1;
        tick();
        chk("wr_resp_cmdout", 32'(cmdout), 32'(C_WRSP));
        chk("wr_resp_addr", addrdataout, addr);
        chk("wr_resp_lenout", 32'(lenout), 32'(len));
        chk("wr_resp_reqtar", 32'(reqtar), 32'(sid));
        ackin = 1'b0;
        tick();
        chk("wr_done_cmdout", 32'(cmdout), 32'(C_IDLE));
        chk("wr_done_reqout", 32'(reqout), 32'd0);
        chk("wr_done_busy", 32'(busy), 32'd0);
    endtask

    // Read request, waits 'wait_cyc' cycles in the bid state (0 = grant
    // already high at the request), then checks 1<<len beats against rbuf.
    task automatic do_read(input logic [31:0] addr, input logic [1:0] len, input logic [3:0] sid,
                           input int wait_cyc);
        int n;
        n = 1 << len;
        drive(1'b1, C_RREQ, len, addr, sid, wait_cyc == 0);
        tick();
        chk("rd_bid_reqout", 32'(reqout), 32'd3);
        chk("rd_bid_cmdout", 32'(cmdout), 32'(C_IDLE));
        drive(1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, wait_cyc == 0);
        for (int w = 1; w < wait_cyc; w++) begin
            tick();
            chk("rd_wait_cmdout", 32'(cmdout), 32'(C_IDLE));
        end
        ackin = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rd_beat_cmdout", 32'(cmdout), 32'(C_RD));
            chk("rd_beat_data", addrdataout, rbuf[i]);
            chk("rd_beat_reqtar", 32'(reqtar), 32'(sid));
            chk("rd_beat_lenout", 32'(lenout), 32'(len));
            chk("rd_beat_reqout", 32'(reqout), 32'd3);
        end
        ackin = 1'b0;
        tick();
        chk("rd_done_reqout", 32'(reqout), 32'd0);
        chk("rd_done_cmdout", 32'(cmdout), 32'(C_IDLE));
        chk("rd_done_data", addrdataout, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;
        tick();

        // Unselected request is ignored.
        drive(1'b0, C_RREQ, 2'b00, 32'h40, 4'd1, 1'b0);
        tick();
        chk("nosel_busy", 32'(busy), 32'd0);

        // Write 4 words at 0x40, then read them back with grant held high.
        wbuf[0] = 32'h0011_2233;
        wbuf[1] = 32'h0022_3344;
        wbuf[2] = 32'h0033_4455;
        wbuf[3] = 32'h0044_5566;
        do_write(32'h40, 2'b10, 4'h5);
        for (int i = 0; i < 4; i++) rbuf[i] = wbuf[i];
        do_read(32'h40, 2'b10, 4'h3, 0);

        // Wrap-around: last word then word 0; upper/low address bits ignored.
        wbuf[0] = 32'hAABB_CCDD;
        wbuf[1] = 32'h1122_3344;
        do_write(32'h0000_0FFC, 2'b01, 4'h1);
        rbuf[0] = 32'hAABB_CCDD;
        rbuf[1] = 32'h1122_3344;
        do_read(32'h0000_3FFF, 2'b01, 4'h1, 2);

        // 8-beat write with stalls, aborted by a read request.
        drive(1'b1, C_WREQ, 2'b11, 32'h100, 4'h7, 1'b0);
        tick();
        drive(1'b0, C_WD, 2'b00, 32'hA0A0_0001, 4'd0, 1'b0); tick();
        drive(1'b0, C_IDLE, 2'b00, 32'hDEAD_BEEF, 4'd0, 1'b0); tick();
        drive(1'b0, C_WD, 2'b00, 32'hA0A0_0002, 4'd0, 1'b0); tick();
        drive(1'b0, C_IDLE, 2'b00, 32'hDEAD_BEEF, 4'd0, 1'b0); tick();
        drive(1'b0, C_WD, 2'b00, 32'hA0A0_0003, 4'd0, 1'b0); tick();
        chk("abort_pre_busy", 32'(busy), 32'd1);
        drive(1'b1, C_RREQ, 2'b00, 32'h40, 4'h7, 1'b0);
        tick();
        chk("abort_err_cnt", 32'(err_cnt), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_reqout", 32'(reqout), 32'd0);
        drive(1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, 1'b1);
        tick();
        chk("abort_no_resp", 32'(cmdout), 32'(C_IDLE));
        chk("abort_still_idle", 32'(busy), 32'd0);
        ackin = 1'b0;
        rbuf[0] = 32'hA0A0_0001;
        rbuf[1] = 32'hA0A0_0002;
        do_read(32'h100, 2'b01, 4'h8, 1);
        rbuf[0] = 32'hA0A0_0003;
        do_read(32'h108, 2'b00, 4'h9, 1);

        // Second request while waiting for the grant is dropped.
        drive(1'b1, C_RREQ, 2'b00, 32'h40, 4'h2, 1'b0);
        tick();
        drive(1'b1, C_RREQ, 2'b01, 32'h100, 4'h9, 1'b0);
        tick();
        chk("dup_err_cnt", 32'(err_cnt), 32'd2);
        chk("dup_cmdout", 32'(cmdout), 32'(C_IDLE));
        chk("dup_reqout", 32'(reqout), 32'd3);
        drive(1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, 1'b1);
        tick();
        chk("dup_beat_cmd", 32'(cmdout), 32'(C_RD));
        chk("dup_beat_data", addrdataout, 32'h0011_2233);
        chk("dup_beat_reqtar", 32'(reqtar), 32'h2);
        ackin = 1'b0;
        tick();
        chk("dup_done_busy", 32'(busy), 32'd0);

        // Error counter saturation.
        drive(1'b1, C_RREQ, 2'b00, 32'h44, 4'h1, 1'b0);
        tick();
        repeat (300) tick();
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
        drive(1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, 1'b1);
        tick();
        chk("sat_beat_data", addrdataout, 32'h0022_3344);
        ackin = 1'b0;
        tick();

        // Reset during beat 2 of an 8-beat read; memory must survive.
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hC000_0000 + 32'(i);
        do_write(32'h200, 2'b11, 4'h6);
        drive(1'b1, C_RREQ, 2'b11, 32'h200, 4'h6, 1'b1);
        tick();
        drive(1'b0, C_IDLE, 2'b00, 32'd0, 4'd0, 1'b1);
        tick();
        chk("rst_beat1", addrdataout, 32'hC000_0000);
        tick();
        chk("rst_beat2", addrdataout, 32'hC000_0001);
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        tick();
        reset_n = 1'b1;
        ackin = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_cmdout", 32'(cmdout), 32'(C_IDLE));
        for (int i = 0; i < 8; i++) rbuf[i] = wbuf[i];
        do_read(32'h200, 2'b11, 4'h6, 1);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
